vga_scanout: RTL and testbench
==============================

VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 SHALL have parameter H_VIS, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameter V_VIS, default 480, meaning visible lines per frame.
REQ-003 SHALL have parameter FB_W, default 320, meaning framebuffer width in pixels (scale 2x to H_VIS).
REQ-004 SHALL have parameter FB_H, default 240, meaning framebuffer height in lines (scale 2x to V_VIS).
REQ-005 SHALL have port CLOCK_50  in  1  system clock, 50 MHz, the only clock.
REQ-006 SHALL have port resetn  in  1  reset; asynchronous, active-low.
REQ-007 SHALL have port x  in  9  write column, 0..FB_W-1.
REQ-008 SHALL have port y  in  8  write row, 0..FB_H-1.
REQ-009 SHALL have port color  in  16  write colour as {R[15:12],G[11:8],B[7:4],unused[3:0]}.
REQ-010 SHALL have port writeEn  in  1  pixel write strobe, one pixel per high cycle.
REQ-011 SHALL have ports vga_r, vga_g, vga_b  out  4 each  pixel colour.
REQ-012 SHALL have ports vga_hs, vga_vs  out  1 each  syncs, active-low.
REQ-013 SHALL have port vga_blank_n  out  1  high while in the visible area.
REQ-014 SHALL have port frame_start  out  1  one-cycle pulse at the first visible pixel of each frame.

Function
REQ-015 SHALL derive a pixel tick on every second CLOCK_50 cycle (25 MHz), with all scan counters advancing only on the tick.
REQ-016 SHALL run hcount 0..799 (visible 0..639, front porch 16, sync 96 at 656..751, back porch 48) and wrap to 0.
REQ-017 SHALL increment vcount when hcount wraps and run vcount 0..524 (visible 0..479, front porch 10, sync 2 at 490..491, back porch 33), then wrap to 0.
REQ-018 SHALL store 3 bits per pixel: R=color[15], G=color[11], B=color[7].
REQ-019 SHALL form the framebuffer address as y*320+x = (y<<8)+(y<<6)+x, 17 bits, with no multiplier.
REQ-020 SHALL write the framebuffer in the same cycle writeEn=1 with x<FB_W and y<FB_H.
REQ-021 SHALL ignore writes with x>=FB_W or y>=FB_H, with no wrap-around and no aliasing.
REQ-022 SHALL read the framebuffer at address (vcount>>1)*320+(hcount>>1) during the visible area.
REQ-023 SHALL drive each output colour nibble as the stored bit replicated 4x, and 4'h0 when not visible.
REQ-024 SHALL register the read and output stages, with rgb, vga_hs, vga_vs, vga_blank_n and frame_start aligned at a fixed 2 CLOCK_50 cycles after the counter value that produced them.
REQ-025 SHALL, on a simultaneous write and read of the same address, return the old data to the read; the new value appears on the next frame.
REQ-026 SHALL accept writes at any time, including blanking and mid-scan; tearing is acceptable.

Reset
REQ-027 SHALL, while resetn=0: hold hcount=vcount=0 and tick phase=0, rgb=0, vga_hs=vga_vs=1, vga_blank_n=0, frame_start=0.
REQ-028 SHALL NOT clear framebuffer contents on reset, and SHALL not specify the power-up contents.
REQ-029 SHALL, on reset asserted mid-frame, force the outputs to their reset values within the asynchronous reset path, and restart the frame at hcount=vcount=0 after deassertion.

Structure
REQ-030 SHALL place the timing constants (visible, porch and sync lengths, totals) and FB_W/FB_H in shared package vga_pkg.
REQ-031 SHALL put the storage in one sub-module, fb_ram: a simple dual-port RAM of 76800x3 bits with registered read and inferable block RAM, with no reset.

Verification
REQ-032 SHALL cover: reset released -> vga_hs low for 192 clk in every 1600 clk, low starting 1312 clk after the line start.
REQ-033 SHALL cover: run 2 frames -> vga_vs low for 2 lines (3200 clk) per 525 lines; frame_start pulses exactly once per 840000 clk.
REQ-034 SHALL cover: write (x=0,y=0,color=16'hF00F) -> screen pixels (0..1,0..1) give vga_r=4'hF, vga_g=4'h0, vga_b=4'h0, and pixel (2,0) gives the old value.
REQ-035 SHALL cover: write (x=319,y=239,color=16'hFFFF), then (x=320,y=0,16'h0F0F) -> screen (638..639,478..479) is white, and address 0 is unchanged.
REQ-036 SHALL cover: resetn pulsed low at hcount=300, vcount=100 -> rgb=0, syncs high, blank_n=0 immediately; the next frame_start comes 2 clk after the first visible tick.
REQ-037 SHALL cover: write to address (10,5) in the same cycle as it is read -> old colour on this frame, new colour on the next frame.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared VGA 640x480@60 timing constants, framebuffer geometry and
//            a shift-add framebuffer address helper.
// Revision : 1.0  initial release
// ============================================================================
package vga_pkg;

  // Default visible area and framebuffer size (framebuffer is scaled 2x)
  localparam int H_VIS_DEF = 640;
  localparam int V_VIS_DEF = 480;
  localparam int FB_W      = 320;
  localparam int FB_H      = 240;

  // Horizontal blanking in pixel ticks
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VIS_DEF + H_FP + H_SYNC + H_BP;  // 800

  // Vertical blanking in lines
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VIS_DEF + V_FP + V_SYNC + V_BP;  // 525

  // Scan counter and framebuffer address widths
  localparam int CNT_W     = 10;
  localparam int ADDR_W    = 17;

  // row*width+col built from shifted copies of row, one per set bit of the
  // constant width; for 320 this collapses to (row<<8)+(row<<6)+col.
  function automatic logic [ADDR_W-1:0] fb_addr(
    input logic [7:0] row,
    input logic [8:0] col,
    input int         width
  );
    logic [ADDR_W-1:0] acc;
    acc = ADDR_W'(col);
    for (int i = 0; i < ADDR_W; i++) begin
      if (width[i]) acc = acc + (ADDR_W'(row) << i);
    end
    return acc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_ram.sv
`default_nettype none
// ============================================================================
// Module   : fb_ram
// Purpose  : Simple dual-port framebuffer RAM, one write port and one
//            registered read port, no reset, read-old-data on collision.
// Revision : 1.0  initial release
// ============================================================================
module fb_ram #(
  parameter int DEPTH  = 76800,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0]  r_mem [0:DEPTH-1];
  logic [DATA_W-1:0]  r_rdata;
  logic [c_idx_w-1:0] w_widx;
  logic [c_idx_w-1:0] w_ridx;

  assign w_widx  = i_waddr[c_idx_w-1:0];
  assign w_ridx  = i_raddr[c_idx_w-1:0];
  assign o_rdata = r_rdata;

  // Address bits above the array size are always zero from the caller
  if (c_idx_w < ADDR_W) begin : g_addr_hi
    logic w_unused_hi;
    assign w_unused_hi = ^{i_waddr[ADDR_W-1:c_idx_w], i_raddr[ADDR_W-1:c_idx_w]};
  end

  // Write port
  always_ff @(posedge clk) begin
    if (i_we) r_mem[w_widx] <= i_wdata;
  end

  // Registered read port; a same-edge write is not visible until next read
  always_ff @(posedge clk) begin
    if (i_re) r_rdata <= r_mem[w_ridx];
  end

endmodule
`default_nettype wire

// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
// Module   : vga_scanout
// Purpose  : 3-bit-per-pixel framebuffer with 2x scaled VGA scan-out. Pixel
//            tick is CLOCK_50/2; outputs lag the scan counters by two clocks.
// Revision : 1.0  initial release
// ============================================================================
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_VIS = H_VIS_DEF,
  parameter int V_VIS = V_VIS_DEF,
  parameter int FB_W  = vga_pkg::FB_W,
  parameter int FB_H  = vga_pkg::FB_H
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic [8:0]  x,
  input  logic [7:0]  y,
  input  logic [15:0] color,
  input  logic        writeEn,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        frame_start
);

  localparam int c_h_total = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int c_hs_beg  = H_VIS + H_FP;
  localparam int c_hs_end  = c_hs_beg + H_SYNC;
  localparam int c_vs_beg  = V_VIS + V_FP;
  localparam int c_vs_end  = c_vs_beg + V_SYNC;
  localparam logic [CNT_W-1:0] c_h_last = CNT_W'(c_h_total - 1);
  localparam logic [CNT_W-1:0] c_v_last = CNT_W'(c_v_total - 1);

  logic             r_tick;
  logic [CNT_W-1:0] r_hcount;
  logic [CNT_W-1:0] r_vcount;
  logic             r_vis1, r_hs1, r_vs1, r_fs1;
  logic [11:0]      r_rgb;
  logic             r_hs, r_vs, r_blank_n, r_fs;

  logic              w_visible, w_hs_n, w_vs_n, w_fs;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr, w_rd_addr;
  logic [2:0]        w_wr_bits, w_rd_bits;
  logic              w_unused;

  // Only the top bit of each colour channel is stored
  assign w_unused  = ^{color[14:12], color[10:8], color[6:0]};
  assign w_wr_bits = {color[15], color[11], color[7]};
  assign w_wr_en   = writeEn && (int'(x) < FB_W) && (int'(y) < FB_H);
  assign w_wr_addr = fb_addr(y, x, FB_W);
  assign w_rd_addr = fb_addr(r_vcount[8:1], r_hcount[9:1], FB_W);

  assign w_visible = (int'(r_hcount) < H_VIS) && (int'(r_vcount) < V_VIS);
  assign w_hs_n    = !((int'(r_hcount) >= c_hs_beg) && (int'(r_hcount) < c_hs_end));
  assign w_vs_n    = !((int'(r_vcount) >= c_vs_beg) && (int'(r_vcount) < c_vs_end));
  // Pulse only on the first of the two clocks of pixel (0,0)
  assign w_fs      = (r_hcount == '0) && (r_vcount == '0) && !r_tick;

  // Pixel tick phase and scan counters, advancing on the second clock of a tick
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_tick   <= 1'b0;
      r_hcount <= '0;
      r_vcount <= '0;
    end else begin
      r_tick <= ~r_tick;
      if (r_tick) begin
        if (r_hcount == c_h_last) begin
          r_hcount <= '0;
          r_vcount <= (r_vcount == c_v_last) ? '0 : r_vcount + 1'b1;
        end else begin
          r_hcount <= r_hcount + 1'b1;
        end
      end
    end
  end

  fb_ram #(
    .DEPTH  (FB_W * FB_H),
    .ADDR_W (ADDR_W),
    .DATA_W (3)
  ) u_fb_ram (
    .clk     (CLOCK_50),
    .i_we    (w_wr_en),
    .i_waddr (w_wr_addr),
    .i_wdata (w_wr_bits),
    .i_re    (w_visible),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_bits)
  );

  // First stage: timing flags delayed to line up with the RAM read data
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_vis1 <= 1'b0;
      r_hs1  <= 1'b1;
      r_vs1  <= 1'b1;
      r_fs1  <= 1'b0;
    end else begin
      r_vis1 <= w_visible;
      r_hs1  <= w_hs_n;
      r_vs1  <= w_vs_n;
      r_fs1  <= w_fs;
    end
  end

  // Output stage: expand stored bits to nibbles, black outside visible area
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_rgb     <= 12'h000;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
      r_fs      <= 1'b0;
    end else begin
      r_rgb     <= r_vis1 ? {{4{w_rd_bits[2]}}, {4{w_rd_bits[1]}}, {4{w_rd_bits[0]}}} : 12'h000;
      r_hs      <= r_hs1;
      r_vs      <= r_vs1;
      r_blank_n <= r_vis1;
      r_fs      <= r_fs1;
    end
  end

  assign vga_r       = r_rgb[11:8];
  assign vga_g       = r_rgb[7:4];
  assign vga_b       = r_rgb[3:0];
  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign vga_blank_n = r_blank_n;
  assign frame_start = r_fs;

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_scanout
// Purpose  : Scoreboard bench for vga_scanout on a reduced 64x16 screen
//            (32x8 framebuffer) with the standard porch and sync lengths.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_scanout;

  // Reduced geometry; blanking lengths are the standard VGA ones
  localparam int HV = 64, VV = 16, FBW = 32, FBH = 8;
  localparam int HT = HV + 16 + 96 + 48;         // 224 ticks per line
  localparam int VT = VV + 10 + 2 + 33;          // 61 lines per frame
  localparam int LINE_CLK  = 2 * HT;             // 448 clk
  localparam int FRAME_CLK = LINE_CLK * VT;      // 27328 clk

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [8:0]  x = '0;
  logic [7:0]  y = '0;
  logic [15:0] color = '0;
  logic        writeEn = 1'b0;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, frame_start;

  vga_scanout #(.H_VIS(HV), .V_VIS(VV), .FB_W(FBW), .FB_H(FBH)) dut (
    .CLOCK_50    (clk),
    .resetn      (resetn),
    .x           (x),
    .y           (y),
    .color       (color),
    .writeEn     (writeEn),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank_n (vga_blank_n),
    .frame_start (frame_start)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endfunction

  typedef struct {
    int f; int sx; int sy; int ph; logic [11:0] rgb;
  } px_t;
  px_t sb[$];

  function automatic void exp_px(int f, int sx, int sy, int ph, logic [11:0] rgb);
    px_t e;
    e.f = f; e.sx = sx; e.sy = sy; e.ph = ph; e.rgb = rgb;
    sb.push_back(e);
  endfunction

  // Monitor: m = posedges since reset release; output at m reflects scan cycle m-2
  int m = 0;
  int hs_cnt, hs_first, vs_cnt, vs_first, bl_cnt, fs_cnt;

  initial begin
    int c, lc, fc, p, h, v, f;
    hs_cnt = 0; hs_first = -1; vs_cnt = 0; vs_first = -1; bl_cnt = 0; fs_cnt = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        m = 0;
        hs_cnt = 0; hs_first = -1; vs_cnt = 0; vs_first = -1; bl_cnt = 0; fs_cnt = 0;
      end else begin
        m++;
        if (m >= 2) begin
          c  = m - 2;
          lc = c % LINE_CLK;
          fc = c % FRAME_CLK;
          p  = c / 2;
          h  = p % HT;
          v  = (p / HT) % VT;
          f  = p / (HT * VT);
          if (!vga_hs) begin hs_cnt++; if (hs_first < 0) hs_first = lc; end
          if (!vga_vs) begin vs_cnt++; if (vs_first < 0) vs_first = fc; end
          if (vga_blank_n) bl_cnt++;
          if (frame_start) begin fs_cnt++; chk("fs_pos", fc, 0); end
          if (sb.size() > 0) begin
            if (sb[0].f == f && sb[0].sx == h && sb[0].sy == v && sb[0].ph == (c % 2)) begin
              n_chk++;
              if ({vga_r, vga_g, vga_b} !== sb[0].rgb) begin
                n_err++;
                $display("FAIL pixel f%0d (%0d,%0d) ph%0d: got %h expected %h",
                         f, h, v, c % 2, {vga_r, vga_g, vga_b}, sb[0].rgb);
              end
              void'(sb.pop_front());
            end
          end
          if (lc == LINE_CLK - 1) begin
            chk("hs_low_len", hs_cnt, 192);
            chk("hs_low_start", hs_first, 2 * (HV + 16));
            hs_cnt = 0; hs_first = -1;
          end
          if (fc == FRAME_CLK - 1) begin
            chk("vs_low_len", vs_cnt, 2 * LINE_CLK);
            chk("vs_low_start", vs_first, (VV + 10) * LINE_CLK);
            chk("blank_n_high", bl_cnt, 2 * HV * VV);
            chk("fs_per_frame", fs_cnt, 1);
            vs_cnt = 0; vs_first = -1; bl_cnt = 0; fs_cnt = 0;
          end
        end
      end
    end
  end

  task automatic go_to(input int tgt);
    int guard;
    guard = 0;
    do begin
      @(negedge clk); #1;
      guard++;
    end while (m != tgt && guard < 100000);
    if (m != tgt) begin
      n_err++;
      $display("FAIL go_to: reached m=%0d target=%0d", m, tgt);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $fatal(1, "timeout");
    end
  endtask

  task automatic write_px(input int xi, input int yi, input logic [15:0] col);
    x = 9'(xi); y = 8'(yi); color = col; writeEn = 1'b1;
    @(negedge clk); #1;
    writeEn = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rgb"}, int'({vga_r, vga_g, vga_b}), 0);
    chk({tag, "_hs"}, int'(vga_hs), 1);
    chk({tag, "_vs"}, int'(vga_vs), 1);
    chk({tag, "_blank_n"}, int'(vga_blank_n), 0);
    chk({tag, "_fs"}, int'(frame_start), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    #2 resetn = 1'b1;

    // Frame 0 vertical blanking: load test pattern
    go_to(2 * 17 * HT);
    write_px(1, 0, 16'h00F0);          // blue
    write_px(0, 0, 16'hF00F);          // red (low nibble ignored)
    write_px(0, 1, 16'h0000);          // black
    write_px(FBW - 1, FBH - 1, 16'hFFFF);
    write_px(FBW, 0, 16'h0F0F);        // x out of range: must not land anywhere
    write_px(10, 5, 16'hF000);         // red

    exp_px(1, 0, 0, 0, 12'hF00);
    exp_px(1, 1, 0, 0, 12'hF00);
    exp_px(1, 2, 0, 0, 12'h00F);
    exp_px(1, HV, 0, 0, 12'h000);
    exp_px(1, 0, 1, 0, 12'hF00);
    exp_px(1, 1, 1, 0, 12'hF00);
    exp_px(1, 0, 2, 0, 12'h000);
    exp_px(1, 1, 2, 0, 12'h000);
    exp_px(1, 20, 10, 0, 12'hF00);
    exp_px(1, 21, 11, 0, 12'hF00);
    exp_px(1, 21, 11, 1, 12'hF00);     // collides with the rewrite below: old data
    exp_px(1, HV - 2, VV - 2, 0, 12'hFFF);
    exp_px(1, HV - 1, VV - 2, 0, 12'hFFF);
    exp_px(1, HV - 2, VV - 1, 0, 12'hFFF);
    exp_px(1, HV - 1, VV - 1, 0, 12'hFFF);
    exp_px(2, 0, 0, 0, 12'hF00);
    exp_px(2, 20, 10, 0, 12'h0F0);
    exp_px(2, 21, 11, 0, 12'h0F0);

    // Rewrite fb(10,5) on the last clock it is read in frame 1
    go_to(FRAME_CLK + 2 * (11 * HT + 21) + 1);
    write_px(10, 5, 16'h0F00);         // green

    // Mid-frame reset at hcount=100, vcount=12 of frame 2
    go_to(2 * FRAME_CLK + 2 * (12 * HT + 100));
    chk("sb_drain_pre_reset", sb.size(), 0);
    resetn = 1'b0;
    #1;
    chk_reset_outputs("mid");
    repeat (3) @(negedge clk);
    exp_px(0, 0, 0, 0, 12'hF00);       // contents survive reset
    #2 resetn = 1'b1;

    go_to(LINE_CLK + 4);
    chk("fs_after_reset", fs_cnt, 1);
    chk("sb_drain_final", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
